// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared state encoding and chunk-count derivation for sub64_iter
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a one-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chunk_sub.sv
// rtl/chunk_sub.sv - combinational CHUNK-bit ripple subtractor d = a - b - bin
module chunk_sub #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             bin,
    output logic [CHUNK-1:0] d,
    output logic             bout
);

    always_comb begin
        logic br;
        br = bin;
        d  = '0;
        for (int i = 0; i < CHUNK; i++) begin
            d[i] = a[i] ^ b[i] ^ br;
            br   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
        end
        bout = br;
    end

endmodule

// File: rtl/sub64_iter.sv
// rtl/sub64_iter.sv - multi-cycle subtractor, CHUNK bits per cycle LSB first
// Optional signed overflow output enabled by defining SUB_OVERFLOW_EN.
module sub64_iter
    import sub_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
`ifdef SUB_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             borrow_out
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int CW     = cnt_width(NCHUNK);
    localparam int IW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_r, b_r;
    logic             borrow_r;
    logic [IW-1:0]    base;
    logic [CHUNK-1:0] d_chunk;
    logic             bout;
    logic             accept, last;

    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (state == CALC) && (cnt == CW'(NCHUNK - 1));
    assign base   = IW'(cnt) * IW'(CHUNK);

    chunk_sub #(.CHUNK(CHUNK)) u_chunk_sub (
        .a    (a_r[base +: CHUNK]),
        .b    (b_r[base +: CHUNK]),
        .bin  (borrow_r),
        .d    (d_chunk),
        .bout (bout)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CALC);
        done = (state == DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_r        <= '0;
            b_r        <= '0;
            borrow_r   <= 1'b0;
            cnt        <= '0;
            D          <= '0;
            borrow_out <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            overflow   <= 1'b0;
`endif
        end else if (accept) begin
            a_r        <= A;
            b_r        <= B;
            borrow_r   <= borrow_in;
            cnt        <= '0;
            D          <= '0;
            borrow_out <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            overflow   <= 1'b0;
`endif
        end else if (state == CALC) begin
            D[base +: CHUNK] <= d_chunk;
            borrow_r         <= bout;
            cnt              <= last ? '0 : cnt + 1'b1;
            if (last) begin
                borrow_out <= bout;
`ifdef SUB_OVERFLOW_EN
                // d_chunk's top bit is the final sign bit of D.
                overflow   <= (a_r[WIDTH-1] != b_r[WIDTH-1]) &&
                              (d_chunk[CHUNK-1] != a_r[WIDTH-1]);
`endif
            end
        end
    end

endmodule

// File: tb/tb_sub64_iter.sv
// tb/tb_sub64_iter.sv - self-checking bench for sub64_iter against an arithmetic reference
module tb_sub64_iter;

    logic        clock;
    logic        reset;
    logic        start;
    logic [63:0] A, B;
    logic        borrow_in;
    logic        busy, done;
    logic [63:0] D;
    logic        borrow_out;
`ifdef SUB_OVERFLOW_EN
    logic        overflow;
    localparam int N_RAND = 10000;
`else
    localparam int N_RAND = 500;
`endif

    int checks = 0;
    int errors = 0;

    sub64_iter dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .A          (A),
        .B          (B),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .D          (D),
`ifdef SUB_OVERFLOW_EN
        .overflow   (overflow),
`endif
        .borrow_out (borrow_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [64:0] ref_sub(input logic [63:0] a, input logic [63:0] b,
                                            input logic bin);
        return {1'b0, a} - {1'b0, b} - {64'd0, bin};
    endfunction

    function automatic logic ref_ovf(input logic [63:0] a, input logic [63:0] b,
                                     input logic bin);
        logic signed [65:0] s;
        logic signed [65:0] maxs;
        logic signed [65:0] mins;
        maxs = 66'sh0_7FFF_FFFF_FFFF_FFFF;
        mins = -66'sh0_8000_0000_0000_0000;
        s = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b}) - $signed({65'd0, bin});
        return (s > maxs) || (s < mins);
    endfunction

    task automatic launch(input logic [63:0] a, input logic [63:0] b, input logic bin);
        A = a; B = b; borrow_in = bin; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int n, output int bn);
        n = 0; bn = 0;
        while (!done && n < 20) begin
            if (busy) bn++;
            @(negedge clock);
            n++;
        end
        chk({tag, " done_seen"}, 64'(done), 64'd1);
    endtask

    task automatic check_result(input string tag, input logic [63:0] a, input logic [63:0] b,
                                input logic bin);
        logic [64:0] r;
        r = ref_sub(a, b, bin);
        chk({tag, " D"}, D, r[63:0]);
        chk({tag, " borrow_out"}, 64'(borrow_out), 64'(r[64]));
`ifdef SUB_OVERFLOW_EN
        chk({tag, " overflow"}, 64'(overflow), 64'(ref_ovf(a, b, bin)));
`endif
    endtask

    task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic bin, input bit timing);
        int n, bn;
        launch(a, b, bin);
        wait_done(tag, n, bn);
        if (timing) begin
            chk({tag, " latency"}, 64'(n), 64'd4);
            chk({tag, " busy_cycles"}, 64'(bn), 64'd4);
        end
        check_result(tag, a, b, bin);
        @(negedge clock);
        chk({tag, " done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int n, bn, hits;
        logic [63:0] ra, rb;
        logic        rbin;

        reset = 1'b1; start = 1'b0; A = '0; B = '0; borrow_in = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset D", D, 64'd0);
        chk("reset borrow_out", 64'(borrow_out), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        do_op("t1 zero", 64'd0, 64'd0, 1'b0, 1'b1);
        do_op("t2 0-1", 64'd0, 64'd1, 1'b0, 1'b1);
        chk("t2 D ones", D, 64'hFFFF_FFFF_FFFF_FFFF);
        do_op("t2b 0-0-1", 64'd0, 64'd0, 1'b1, 1'b0);
        do_op("t3 ripple", 64'h0001_0000_0000_0000, 64'd1, 1'b0, 1'b1);
        chk("t3 D exact", D, 64'h0000_FFFF_FFFF_FFFF);

        // start during CALC must be ignored, then back-to-back from DONE
        launch(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
        @(negedge clock);
        launch(64'hDEAD_BEEF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        wait_done("t4 ignore", n, bn);
        chk("t4 ignore latency", 64'(n), 64'd2);
        check_result("t4 ignore", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
        launch(64'h0000_0000_FFFF_0000, 64'h0000_0001_0000_0001, 1'b0);
        chk("t4 b2b done_drop", 64'(done), 64'd0);
        chk("t4 b2b busy", 64'(busy), 64'd1);
        chk("t4 b2b D_clear", D, 64'd0);
        wait_done("t4 b2b", n, bn);
        chk("t4 b2b latency", 64'(n), 64'd4);
        check_result("t4 b2b", 64'h0000_0000_FFFF_0000, 64'h0000_0001_0000_0001, 1'b0);
        @(negedge clock);
        chk("t4 b2b done_pulse", 64'(done), 64'd0);

        // reset in the middle of CALC
        launch(64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF, 1'b1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("t5 rst busy", 64'(busy), 64'd0);
        chk("t5 rst done", 64'(done), 64'd0);
        chk("t5 rst D", D, 64'd0);
        chk("t5 rst borrow_out", 64'(borrow_out), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        hits = 0;
        repeat (8) begin
            @(negedge clock);
            if (done || busy) hits++;
        end
        chk("t5 no_done_after_rst", 64'(hits), 64'd0);
        do_op("t5 recover", 64'h0000_0000_0000_0005, 64'h0000_0000_0000_0007, 1'b0, 1'b1);

`ifdef SUB_OVERFLOW_EN
        do_op("t6 ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
        chk("t6 ovf D", D, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("t6 ovf bit", 64'(overflow), 64'd1);
`endif

        for (int i = 0; i < N_RAND; i++) begin
            ra   = {$urandom, $urandom};
            rb   = {$urandom, $urandom};
            rbin = 1'($urandom);
            case ($urandom_range(0, 7))
                0: ra = rb;
                1: rb = 64'h8000_0000_0000_0000;
                2: ra = {ra[63:16], 16'h0000};
                default: ;
            endcase
            do_op("rand", ra, rb, rbin, (i % 64) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
